spi_slave_core: RTL and testbench



---
 rtl/spi_slave_core.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: synchronises sclk/ss_n/mosi into clk, shifts MSB-first words in and out.
// Optional SPI_SLAVE_UNDERRUN_EN enables the tx_underrun pulse on loads from an empty buffer.
module spi_slave_core #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         ss_n,
  input  logic         mosi,
  output logic         miso,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         tx_underrun
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  state_e                 state_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [W-1:0]           rx_shift_q, tx_shift_q, tx_buf_q, rx_data_q;
  logic                   tx_ready_q, rx_valid_q, miso_q, busy_q;

  logic          sclk_s, ss_s, mosi_s, sclk_rise_s, sclk_fall_s;
  logic          load_s, wr_s;
  logic [W-1:0]  load_word_d, rx_shift_d;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;

  // A load happens on select, and on the falling edge that closes each word.
  assign load_s = ~ss_s & ((state_q == IDLE) |
                  ((state_q == ACTIVE) & sclk_fall_s & (bit_cnt_q == {CW{1'b0}})));
  assign wr_s        = tx_valid & tx_ready_q;
  assign load_word_d = tx_ready_q ? {W{1'b0}} : tx_buf_q;
  assign rx_shift_d  = {rx_shift_q[W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  // A write landing with a load refills the buffer, so it stays full.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf_q   <= {W{1'b0}};
      tx_ready_q <= 1'b1;
    end else if (wr_s) begin
      tx_buf_q   <= tx_data;
      tx_ready_q <= 1'b0;
    end else if (load_s) begin
      tx_ready_q <= 1'b1;
    end else begin
      tx_ready_q <= tx_ready_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= {CW{1'b0}};
      rx_shift_q <= {W{1'b0}};
      tx_shift_q <= {W{1'b0}};
      rx_data_q  <= {W{1'b0}};
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= {CW{1'b0}};
          miso_q    <= 1'b0;
          if (load_s) begin
            tx_shift_q <= load_word_d;
            miso_q     <= load_word_d[W-1];
            state_q    <= ACTIVE;
            busy_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_s) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            bit_cnt_q  <= {CW{1'b0}};
            rx_shift_q <= {W{1'b0}};
            tx_shift_q <= {W{1'b0}};
            miso_q     <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == CW'(W - 1)) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= {CW{1'b0}};
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end else if (sclk_fall_s) begin
            if (load_s) begin
              tx_shift_q <= load_word_d;
              miso_q     <= load_word_d[W-1];
            end else begin
              tx_shift_q <= {tx_shift_q[W-2:0], 1'b0};
              miso_q     <= tx_shift_q[W-2];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= load_s & tx_ready_q;
    end
  end

  assign tx_underrun = underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: a bit-banged SPI master drives frames, monitors compare words.
module tb_spi_slave_core;

  localparam int HALF = 5;
`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam int UND_EXP = 1;
`else
  localparam int UND_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, sclk, ss_n, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy, tx_underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int und_cnt  = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] miso_word;
  event       miso_done;

  spi_slave_core #(.W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Received-word monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
    end
    if (tx_underrun) und_cnt++;
  end

  // Word the master sampled from miso.
  always begin
    @(miso_done);
    if (exp_tx_q.size() == 0) check("miso_unexpected", {24'd0, miso_word}, 32'hFFFF_FFFF);
    else check("miso_word", {24'd0, miso_word}, {24'd0, exp_tx_q.pop_front()});
  end

  task automatic spi_bits(input int nb, input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk) mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [7:0] mo, input logic [7:0] exp_mi);
    logic [7:0] got;
    exp_rx_q.push_back(mo);
    exp_tx_q.push_back(exp_mi);
    spi_bits(8, mo, got);
    miso_word = got;
    -> miso_done;
  endtask

  task automatic ss_low(input int exp_und);
    @(negedge clk);
    und_cnt = 0;
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check("underrun_at_select", und_cnt, exp_und);
    check("busy_active", {31'd0, busy}, 32'd1);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] dummy;
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    reset = 1'b0;

    // Single word exchange.
    write_tx(8'hA5);
    ss_low(0);
    check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
    spi_word(8'h3C, 8'hA5);
    ss_high();

    // Two back-to-back words in one frame.
    write_tx(8'h11);
    ss_low(0);
    write_tx(8'h22);
    spi_word(8'hC3, 8'h11);
    spi_word(8'h5A, 8'h22);
    ss_high();
    check("tx_ready_after_frame", {31'd0, tx_ready}, 32'd1);

    // Empty buffer sends zeros.
    ss_low(UND_EXP);
    spi_word(8'hFF, 8'h00);
    ss_high();

    // Aborted partial word, then a full one.
    ss_low(UND_EXP);
    spi_bits(5, 8'hFF, dummy);
    ss_high();
    write_tx(8'h96);
    ss_low(0);
    spi_word(8'h81, 8'h96);
    ss_high();
    check("rx_data_hold", {24'd0, rx_data}, 32'h81);

    // Reset in the middle of a frame with the buffer full.
    write_tx(8'h33);
    ss_low(0);
    write_tx(8'h44);
    spi_bits(3, 8'hE0, dummy);
    @(negedge clk);
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    write_tx(8'h0F);
    ss_low(0);
    spi_word(8'hE7, 8'h0F);
    ss_high();

    // Writes while full are ignored.
    @(negedge clk);
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h77;
    repeat (3) @(negedge clk);
    check("tx_ready_held_full", {31'd0, tx_ready}, 32'd0);
    tx_valid = 1'b0;
    ss_low(0);
    spi_word(8'h00, 8'h5A);
    ss_high();

    repeat (10) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 32'd0);
    check("tx_queue_drained", exp_tx_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
